// File: rtl/or_event_counter.sv
// Synchronises and debounces an asynchronous OR-gate output, then counts its
// qualified rising events with sticky threshold and overflow flags.
module or_event_counter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter bit SATURATE    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c_in,
    input  logic             clr,
    input  logic [CNT_W-1:0] thresh,
    output logic             level,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] count,
    output logic             thr_hit,
    output logic             overflow
);

    localparam int                STAB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    state_t                 state_q;
    logic [STAB_W-1:0]      stab_q;
    logic                   level_q;
    logic                   edge_pulse_q;
    logic                   qual_s;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic [CNT_W-1:0]       count_inc_s;
    logic                   thr_hit_q;
    logic                   thr_hit_d;
    logic                   overflow_q;
    logic                   overflow_d;

    assign sync_s      = sync_q[SYNC_STAGES-1];
    // A rise qualifies on the last of DEB_CYCLES consecutive high samples.
    assign qual_s      = (state_q == ST_RISE) && sync_s && (stab_q == STAB_LAST);
    assign count_inc_s = count_q + CNT_ONE;

    // Plain shift-register synchroniser for the asynchronous OR output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], c_in};
        end
    end

    // Debounce FSM with registered level and rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOW;
            stab_q       <= {STAB_W{1'b0}};
            level_q      <= 1'b0;
            edge_pulse_q <= 1'b0;
        end else begin
            edge_pulse_q <= 1'b0;
            case (state_q)
                ST_LOW: begin
                    level_q <= 1'b0;
                    if (sync_s) begin
                        stab_q  <= STAB_ONE;
                        state_q <= ST_RISE;
                    end else begin
                        state_q <= ST_LOW;
                    end
                end
                ST_RISE: begin
                    if (!sync_s) begin
                        state_q <= ST_LOW;
                        level_q <= 1'b0;
                    end else if (qual_s) begin
                        state_q      <= ST_HIGH;
                        level_q      <= 1'b1;
                        edge_pulse_q <= 1'b1;
                    end else begin
                        stab_q  <= stab_q + STAB_ONE;
                        level_q <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    level_q <= 1'b1;
                    if (!sync_s) begin
                        stab_q  <= STAB_ONE;
                        state_q <= ST_FALL;
                    end else begin
                        state_q <= ST_HIGH;
                    end
                end
                ST_FALL: begin
                    if (sync_s) begin
                        state_q <= ST_HIGH;
                        level_q <= 1'b1;
                    end else if (stab_q == STAB_LAST) begin
                        state_q <= ST_LOW;
                        level_q <= 1'b0;
                    end else begin
                        stab_q  <= stab_q + STAB_ONE;
                        level_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_LOW;
                    stab_q  <= {STAB_W{1'b0}};
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    // Event counter next state; clr dominates any coincident event.
    always_comb begin
        count_d    = count_q;
        thr_hit_d  = thr_hit_q;
        overflow_d = overflow_q;
        if (clr) begin
            count_d    = CNT_ZERO;
            thr_hit_d  = 1'b0;
            overflow_d = 1'b0;
        end else if (qual_s) begin
            if (count_q == CNT_MAX) begin
                overflow_d = 1'b1;
                count_d    = SATURATE ? CNT_MAX : CNT_ZERO;
            end else begin
                count_d = count_inc_s;
                if ((thresh != CNT_ZERO) && (count_inc_s == thresh)) begin
                    thr_hit_d = 1'b1;
                end else begin
                    thr_hit_d = thr_hit_q;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= CNT_ZERO;
            thr_hit_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            thr_hit_q  <= thr_hit_d;
            overflow_q <= overflow_d;
        end
    end

    assign level      = level_q;
    assign edge_pulse = edge_pulse_q;
    assign count      = count_q;
    assign thr_hit    = thr_hit_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_or_event_counter.sv
// Randomised bench for or_event_counter: a default instance plus two 3-bit
// counter instances (saturating and wrapping) checked against a queue model.
module tb_or_event_counter;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c_in = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] thresh = 8'd0;
    logic       level, edge_pulse, thr_hit, overflow;
    logic [7:0] count;
    logic       lvl_s, pls_s, thr_s, ovf_s;
    logic       lvl_w, pls_w, thr_w, ovf_w;
    logic [2:0] cnt_s, cnt_w;
    logic [2:0] thr3 = 3'd0;

    int n_pass = 0;
    int n_total = 0;

    // Model state
    logic       sp [SYNC];
    bit         hist [$];
    logic       m_level, m_pulse, m_thr, m_ovf;
    logic [7:0] m_count;
    logic [2:0] m3s, m3w;
    logic       m3s_ovf, m3w_ovf;

    always #5 clk = ~clk;

    or_event_counter u_dut (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .clr(clr), .thresh(thresh),
        .level(level), .edge_pulse(edge_pulse), .count(count),
        .thr_hit(thr_hit), .overflow(overflow)
    );

    or_event_counter #(.CNT_W(3), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .clr(clr), .thresh(thr3),
        .level(lvl_s), .edge_pulse(pls_s), .count(cnt_s),
        .thr_hit(thr_s), .overflow(ovf_s)
    );

    or_event_counter #(.CNT_W(3), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .clr(clr), .thresh(thr3),
        .level(lvl_w), .edge_pulse(pls_w), .count(cnt_w),
        .thr_hit(thr_w), .overflow(ovf_w)
    );

    function automatic logic [19:0] dut_v();
        return {level, edge_pulse, count, thr_hit, overflow, cnt_s, ovf_s, cnt_w, ovf_w};
    endfunction

    function automatic logic [19:0] mdl_v();
        return {m_level, m_pulse, m_count, m_thr, m_ovf, m3s, m3s_ovf, m3w, m3w_ovf};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) sp[i] = 1'b0;
        hist.delete();
        m_level = 1'b0; m_pulse = 1'b0; m_thr = 1'b0; m_ovf = 1'b0;
        m_count = 8'd0; m3s = 3'd0; m3w = 3'd0; m3s_ovf = 1'b0; m3w_ovf = 1'b0;
    endtask

    // Level flips once the last DEB synchronised samples all disagree with it.
    task automatic model_step(input logic c, input logic cl);
        logic s;
        bit   all_diff;
        logic rise;
        s = sp[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) sp[i] = sp[i-1];
        sp[0] = c;
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        rise = 1'b0;
        if (hist.size() == DEB) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = ~m_level;
                rise = m_level;
            end
        end
        m_pulse = rise;
        if (cl) begin
            m_count = 8'd0; m_thr = 1'b0; m_ovf = 1'b0;
            m3s = 3'd0; m3s_ovf = 1'b0; m3w = 3'd0; m3w_ovf = 1'b0;
        end else if (rise) begin
            if (m_count == 8'd255) m_ovf = 1'b1;
            else begin
                m_count = m_count + 8'd1;
                if (thresh != 8'd0 && m_count == thresh) m_thr = 1'b1;
            end
            if (m3s == 3'd7) m3s_ovf = 1'b1;
            else m3s = m3s + 3'd1;
            if (m3w == 3'd7) begin m3w = 3'd0; m3w_ovf = 1'b1; end
            else m3w = m3w + 3'd1;
        end
    endtask

    // Drive at a negedge, step model on the posedge, return at the next negedge.
    task automatic tick(input logic c, input logic cl);
        c_in = c;
        clr  = cl;
        @(posedge clk);
        model_step(c, cl);
        @(negedge clk);
    endtask

    task automatic run(input logic c, input int n);
        for (int i = 0; i < n; i++) tick(c, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_total++;
        if (dut_v() !== 20'd0) $display("FAIL reset_initial: got %h want %h", dut_v(), 20'd0);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin run(1'b1, 6); run(1'b0, 6); end
        n_total++;
        if (count !== 8'd5 || dut_v() !== mdl_v())
            $display("FAIL reset_pre_count: got %h (count %0d) want %h (count 5)", dut_v(), count, mdl_v());
        else n_pass++;
        run(1'b1, 8);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (dut_v() !== 20'd0) $display("FAIL reset_async: got %h want %h", dut_v(), 20'd0);
        else n_pass++;
        #1 rst_n = 1'b1;
        model_reset();
        run(1'b0, 6); run(1'b1, 6);
        n_total++;
        if (count !== 8'd1 || edge_pulse !== 1'b1 || dut_v() !== mdl_v())
            $display("FAIL reset_first_event: got %h want count 1 pulse 1 (%h)", dut_v(), mdl_v());
        else n_pass++;
        run(1'b0, 6);
    endtask

    task automatic test_glitch();
        int n;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n + 6; i++) begin
                tick(i < n, 1'b0);
                n_total++;
                if (level !== 1'b0 || edge_pulse !== 1'b0 || dut_v() !== mdl_v())
                    $display("FAIL glitch len=%0d cyc=%0d: got %h want level 0 (%h)", n, i, dut_v(), mdl_v());
                else n_pass++;
            end
        end
        n_total++;
        if (count !== 8'd1) $display("FAIL glitch_count: got %0d want 1", count);
        else n_pass++;
    endtask

    task automatic test_clean_event();
        tick(1'b0, 1'b1);
        run(1'b0, 4);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0);
            n_total++;
            if (level !== (i >= 5) || edge_pulse !== (i == 5) || dut_v() !== mdl_v())
                $display("FAIL clean_rise edge=%0d: got lvl %b pulse %b want lvl %b pulse %b",
                         i, level, edge_pulse, i >= 5, i == 5);
            else n_pass++;
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            n_total++;
            if (level !== (i < 5) || edge_pulse !== 1'b0 || count !== 8'd1 || dut_v() !== mdl_v())
                $display("FAIL clean_fall edge=%0d: got lvl %b pulse %b cnt %0d want lvl %b pulse 0 cnt 1",
                         i, level, edge_pulse, count, i < 5);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int n;
        run(1'b1, 8);
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n + 6; i++) begin
                tick(i >= n, 1'b0);
                n_total++;
                if (level !== 1'b1 || edge_pulse !== 1'b0 || count !== 8'd2 || dut_v() !== mdl_v())
                    $display("FAIL bounce_high len=%0d cyc=%0d: got %h want lvl 1 cnt 2 (%h)", n, i, dut_v(), mdl_v());
                else n_pass++;
            end
        end
        run(1'b0, 8);
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n + 6; i++) begin
                tick(i < n, 1'b0);
                n_total++;
                if (level !== 1'b0 || edge_pulse !== 1'b0 || count !== 8'd2 || dut_v() !== mdl_v())
                    $display("FAIL bounce_low len=%0d cyc=%0d: got %h want lvl 0 cnt 2 (%h)", n, i, dut_v(), mdl_v());
                else n_pass++;
            end
        end
    endtask

    task automatic test_threshold();
        tick(1'b0, 1'b1);
        thresh = 8'd3;
        run(1'b0, 4);
        for (int k = 1; k <= 5; k++) begin
            run(1'b1, 5);
            n_total++;
            if (thr_hit !== (k > 3) || dut_v() !== mdl_v())
                $display("FAIL thr_before ev=%0d: got thr %b want %b", k, thr_hit, k > 3);
            else n_pass++;
            tick(1'b1, k == 5);
            n_total++;
            if (edge_pulse !== 1'b1 || count !== ((k == 5) ? 8'd0 : 8'(k)) ||
                thr_hit !== (k >= 3 && k != 5) || overflow !== 1'b0 || dut_v() !== mdl_v())
                $display("FAIL thr_event ev=%0d: got pulse %b cnt %0d thr %b want pulse 1 cnt %0d thr %b",
                         k, edge_pulse, count, thr_hit, (k == 5) ? 0 : k, k >= 3 && k != 5);
            else n_pass++;
            run(1'b0, 6);
        end
        run(1'b1, 6); run(1'b0, 6);
        thresh = 8'd1;
        run(1'b0, 3);
        n_total++;
        if (thr_hit !== 1'b0 || count !== 8'd1) $display("FAIL thr_change_only: got thr %b cnt %0d want thr 0 cnt 1", thr_hit, count);
        else n_pass++;
        thresh = 8'd2;
        run(1'b1, 6); run(1'b0, 6);
        n_total++;
        if (thr_hit !== 1'b1 || count !== 8'd2) $display("FAIL thr_reach2: got thr %b cnt %0d want thr 1 cnt 2", thr_hit, count);
        else n_pass++;
        thresh = 8'd0;
    endtask

    task automatic test_overflow();
        logic [2:0] es, ew;
        tick(1'b0, 1'b1);
        run(1'b0, 4);
        for (int k = 1; k <= 9; k++) begin
            run(1'b1, 6); run(1'b0, 6);
            es = (k >= 7) ? 3'd7 : 3'(k);
            ew = 3'(k % 8);
            n_total++;
            if (cnt_s !== es || ovf_s !== (k >= 8) || cnt_w !== ew || ovf_w !== (k >= 8) || dut_v() !== mdl_v())
                $display("FAIL ovf ev=%0d: got sat %0d/%b wrap %0d/%b want sat %0d/%b wrap %0d/%b",
                         k, cnt_s, ovf_s, cnt_w, ovf_w, es, k >= 8, ew, k >= 8);
            else n_pass++;
        end
        tick(1'b0, 1'b1);
        n_total++;
        if (cnt_s !== 3'd0 || ovf_s !== 1'b0 || cnt_w !== 3'd0 || ovf_w !== 1'b0)
            $display("FAIL ovf_clr: got sat %0d/%b wrap %0d/%b want 0/0", cnt_s, ovf_s, cnt_w, ovf_w);
        else n_pass++;
        run(1'b0, 4);
        for (int k = 1; k <= 7; k++) begin run(1'b1, 6); run(1'b0, 6); end
        run(1'b1, 5);
        tick(1'b1, 1'b1);
        n_total++;
        if (cnt_s !== 3'd0 || ovf_s !== 1'b0 || cnt_w !== 3'd0 || ovf_w !== 1'b0 || dut_v() !== mdl_v())
            $display("FAIL ovf_clr_at_max: got sat %0d/%b wrap %0d/%b want 0/0", cnt_s, ovf_s, cnt_w, ovf_w);
        else n_pass++;
        run(1'b0, 6);
    endtask

    task automatic test_random();
        logic c;
        int   len;
        thresh = 8'($urandom_range(1, 12));
        for (int r = 0; r < 80; r++) begin
            c   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                tick(c, $urandom_range(0, 39) == 0);
                n_total++;
                if (dut_v() !== mdl_v())
                    $display("FAIL random run=%0d cyc=%0d: got %h want %h", r, i, dut_v(), mdl_v());
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_clean_event();
        test_bounce();
        test_threshold();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1);
    end

endmodule
